exe_stage: RTL and testbench

- Combinational execute stage of the 5-stage MIPS-style pipeline. Sits between the ID/EXE and EXE/MEM pipeline registers.
- Forwards operands from the MEM and WB stages and performs the ALU operation.
- Resolves branches, driving pc_src and the branch target back to the IF stage (the ID stage also uses pc_src as its flush signal).
- Passes control and destination fields through to the EXE/MEM register.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/exe_stage_if.sv | 42 ++++
 rtl/exe_alu.sv | 25 ++
 rtl/exe_stage.sv | 32 +++
 tb/tb_exe_stage.sv | 137 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU op codes, branch types and MEM_CMD bit positions.
package mips_pkg;
  localparam int XLEN = 32;
  localparam int RIDX = 5;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;
  localparam int MEM_R_BIT = 0;
  localparam int MEM_W_BIT = 1;
  // MEM result beats WB result; register 0 always reads the ID value
  function automatic logic [XLEN-1:0] fwd(
    input logic [RIDX-1:0] src, input logic [XLEN-1:0] id_val,
    input logic mem_en, input logic [RIDX-1:0] mem_dst, input logic [XLEN-1:0] mem_val,
    input logic wb_en, input logic [RIDX-1:0] wb_dst, input logic [XLEN-1:0] wb_val);
    return (src == '0) ? id_val :
           (mem_en && mem_dst == src) ? mem_val :
           (wb_en && wb_dst == src) ? wb_val : id_val;
  endfunction
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EXE, forwarding and EXE/MEM signals of the execute stage.
interface exe_stage_if;
  import mips_pkg::*;
  logic [XLEN-1:0] PC_in;
  logic            WB_EN_EXE;
  logic [1:0]      MEM_CMD_EXE;
  logic [5:0]      EXE_CMD_EXE;
  logic [XLEN-1:0] Val1_EXE;
  logic [XLEN-1:0] Val2_EXE;
  logic [XLEN-1:0] Reg2_EXE;
  logic [RIDX-1:0] Dst_EXE;
  logic [RIDX-1:0] Src1_EXE;
  logic [RIDX-1:0] Src2_EXE;
  logic [RIDX-1:0] Dst_MEM;
  logic            WB_EN_MEM_out;
  logic [XLEN-1:0] Result_Alu_Mem;
  logic [RIDX-1:0] Dst_WB;
  logic            WB_EN_WB_out;
  logic [XLEN-1:0] Result_WB_to_IR;
  logic [XLEN-1:0] PC;
  logic            WB_EN_out_EXE;
  logic [1:0]      MEM_CMD_out_EXE;
  logic [RIDX-1:0] Dst_EXE_out_EXE;
  logic [XLEN-1:0] ALU_res_out_EXE;
  logic [XLEN-1:0] src2_val_out_EXE;
  logic            PC_src_out_EXE;
  logic [XLEN-1:0] br_address_out_EXE;
  modport master (
    output PC_in, WB_EN_EXE, MEM_CMD_EXE, EXE_CMD_EXE, Val1_EXE, Val2_EXE, Reg2_EXE,
           Dst_EXE, Src1_EXE, Src2_EXE, Dst_MEM, WB_EN_MEM_out, Result_Alu_Mem,
           Dst_WB, WB_EN_WB_out, Result_WB_to_IR,
    input  PC, WB_EN_out_EXE, MEM_CMD_out_EXE, Dst_EXE_out_EXE, ALU_res_out_EXE,
           src2_val_out_EXE, PC_src_out_EXE, br_address_out_EXE
  );
  modport slave (
    input  PC_in, WB_EN_EXE, MEM_CMD_EXE, EXE_CMD_EXE, Val1_EXE, Val2_EXE, Reg2_EXE,
           Dst_EXE, Src1_EXE, Src2_EXE, Dst_MEM, WB_EN_MEM_out, Result_Alu_Mem,
           Dst_WB, WB_EN_WB_out, Result_WB_to_IR,
    output PC, WB_EN_out_EXE, MEM_CMD_out_EXE, Dst_EXE_out_EXE, ALU_res_out_EXE,
           src2_val_out_EXE, PC_src_out_EXE, br_address_out_EXE
  );
endinterface

// File: rtl/exe_alu.sv
// exe_alu: 32-bit combinational ALU; unknown op codes yield zero.
module exe_alu
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      ALU_SLA, ALU_SLL: result = a << b[4:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: combinational execute stage with MEM/WB forwarding and branch resolution.
module exe_stage
  import mips_pkg::*;
(
  input logic clk,
  input logic rst,
  exe_stage_if.slave bus
);
  logic [XLEN-1:0] a, r2, b, alu_res;
  logic [1:0] br;
  logic val2_is_reg;
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign br = bus.EXE_CMD_EXE[5:4];
  assign a = fwd(bus.Src1_EXE, bus.Val1_EXE, bus.WB_EN_MEM_out, bus.Dst_MEM, bus.Result_Alu_Mem,
                 bus.WB_EN_WB_out, bus.Dst_WB, bus.Result_WB_to_IR);
  assign r2 = fwd(bus.Src2_EXE, bus.Reg2_EXE, bus.WB_EN_MEM_out, bus.Dst_MEM, bus.Result_Alu_Mem,
                  bus.WB_EN_WB_out, bus.Dst_WB, bus.Result_WB_to_IR);
  // loads, stores and branches carry an immediate in Val2, so only plain ALU ops take rt
  assign val2_is_reg = br == BR_NONE && !bus.MEM_CMD_EXE[MEM_R_BIT] && !bus.MEM_CMD_EXE[MEM_W_BIT]
                       && bus.Src2_EXE != '0;
  assign b = val2_is_reg ? r2 : bus.Val2_EXE;
  exe_alu u_alu (.a(a), .b(b), .op(bus.EXE_CMD_EXE[3:0]), .result(alu_res));
  assign bus.ALU_res_out_EXE = alu_res;
  assign bus.src2_val_out_EXE = r2;
  assign bus.PC_src_out_EXE = br == BR_JMP || (br == BR_BEZ && a == '0) || (br == BR_BNE && a != r2);
  assign bus.br_address_out_EXE = bus.PC_in + {bus.Val2_EXE[29:0], 2'b00};
  assign bus.PC = bus.PC_in;
  assign bus.WB_EN_out_EXE = bus.WB_EN_EXE;
  assign bus.MEM_CMD_out_EXE = bus.MEM_CMD_EXE;
  assign bus.Dst_EXE_out_EXE = bus.Dst_EXE;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vector table plus randomized checks against a behavioural model.
module tb_exe_stage;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  exe_stage_if bus ();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc, v1, v2, r2, rm, rw;
    logic [5:0]  cmd;
    logic [1:0]  mem;
    logic [4:0]  s1, s2, dm, dw, dst;
    logic        em, ew, wb;
    logic [31:0] e_alu, e_s2, e_br;
    logic        e_src;
  } vec_t;

  function automatic vec_t mk(
    logic [31:0] pc, logic [5:0] cmd, logic [1:0] mem, logic [31:0] v1, logic [31:0] v2,
    logic [31:0] r2, logic [4:0] s1, logic [4:0] s2, logic [4:0] dm, logic em, logic [31:0] rm,
    logic [4:0] dw, logic ew, logic [31:0] rw,
    logic [31:0] e_alu, logic [31:0] e_s2, logic e_src, logic [31:0] e_br);
    vec_t v;
    v.pc = pc; v.cmd = cmd; v.mem = mem; v.v1 = v1; v.v2 = v2; v.r2 = r2;
    v.s1 = s1; v.s2 = s2; v.dm = dm; v.em = em; v.rm = rm; v.dw = dw; v.ew = ew; v.rw = rw;
    v.dst = 5'd0; v.wb = 1'b0;
    v.e_alu = e_alu; v.e_s2 = e_s2; v.e_src = e_src; v.e_br = e_br;
    return v;
  endfunction

  // reference: register-file view of the most recent writers, then plain arithmetic
  function automatic logic [31:0] ref_operand(vec_t v, logic [4:0] idx, logic [31:0] id_val);
    logic [31:0] val;
    val = id_val;
    if (idx != 0 && v.ew && v.dw == idx) val = v.rw;
    if (idx != 0 && v.em && v.dm == idx) val = v.rm;
    return val;
  endfunction

  function automatic vec_t ref_model(vec_t v);
    logic [31:0] a, r2, b;
    int sh;
    a = ref_operand(v, v.s1, v.v1);
    r2 = ref_operand(v, v.s2, v.r2);
    b = (v.cmd[5:4] == 0 && v.mem == 0 && v.s2 != 0) ? r2 : v.v2;
    sh = int'(b % 32);
    case (v.cmd[3:0])
      4'd0: v.e_alu = a + b;
      4'd2: v.e_alu = a - b;
      4'd4: v.e_alu = a & b;
      4'd5: v.e_alu = a | b;
      4'd6: v.e_alu = ~(a | b);
      4'd7: v.e_alu = a ^ b;
      4'd8, 4'd9: v.e_alu = a * (32'd1 << sh);
      4'd10: v.e_alu = 32'(longint'(signed'(a)) / (longint'(1) << sh) - ((a[31] && (a % (32'd1 << sh)) != 0) ? 1 : 0));
      4'd11: v.e_alu = a / (32'd1 << sh);
      default: v.e_alu = 0;
    endcase
    v.e_s2 = r2;
    v.e_src = (v.cmd[5:4] == 3) || (v.cmd[5:4] == 1 && a == 0) || (v.cmd[5:4] == 2 && a != r2);
    v.e_br = 32'(64'(v.pc) + 64'(v.v2) * 4);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    bus.PC_in = v.pc; bus.EXE_CMD_EXE = v.cmd; bus.MEM_CMD_EXE = v.mem;
    bus.Val1_EXE = v.v1; bus.Val2_EXE = v.v2; bus.Reg2_EXE = v.r2;
    bus.Src1_EXE = v.s1; bus.Src2_EXE = v.s2; bus.Dst_EXE = v.dst; bus.WB_EN_EXE = v.wb;
    bus.Dst_MEM = v.dm; bus.WB_EN_MEM_out = v.em; bus.Result_Alu_Mem = v.rm;
    bus.Dst_WB = v.dw; bus.WB_EN_WB_out = v.ew; bus.Result_WB_to_IR = v.rw;
    #1;
    chk({tag, " alu"}, bus.ALU_res_out_EXE, v.e_alu);
    chk({tag, " src2"}, bus.src2_val_out_EXE, v.e_s2);
    chk({tag, " pc_src"}, {31'd0, bus.PC_src_out_EXE}, {31'd0, v.e_src});
    chk({tag, " br_addr"}, bus.br_address_out_EXE, v.e_br);
    chk({tag, " pc"}, bus.PC, v.pc);
    chk({tag, " ctrl"}, {24'd0, bus.WB_EN_out_EXE, bus.MEM_CMD_out_EXE, bus.Dst_EXE_out_EXE},
        {24'd0, v.wb, v.mem, v.dst});
  endtask

  vec_t tbl[15];
  vec_t rv;

  initial begin
    tbl[0]  = mk(32'h100, 6'h00, 2'b00, 5, 7, 7, 1, 2, 0, 0, 0, 0, 0, 0, 12, 7, 0, 32'h11C);
    tbl[1]  = mk(0, 6'h02, 2'b00, 0, 1, 0, 3, 0, 3, 1, 100, 3, 1, 200, 99, 0, 0, 4);
    tbl[2]  = mk(0, 6'h02, 2'b00, 0, 1, 0, 3, 0, 3, 0, 100, 3, 1, 200, 199, 0, 0, 4);
    tbl[3]  = mk(0, 6'h00, 2'b00, 0, 4, 0, 0, 0, 0, 1, 55, 0, 0, 0, 4, 0, 0, 16);
    tbl[4]  = mk(0, 6'h00, 2'b10, 32'h10, 8, 0, 0, 4, 0, 0, 0, 4, 1, 32'hDEAD, 32'h18, 32'hDEAD, 0, 32'h20);
    tbl[5]  = mk(32'h40, 6'h20, 2'b00, 1, 3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 4, 2, 1, 32'h4C);
    tbl[6]  = mk(32'h40, 6'h20, 2'b00, 2, 3, 2, 1, 2, 0, 0, 0, 0, 0, 0, 5, 2, 0, 32'h4C);
    tbl[7]  = mk(32'h40, 6'h10, 2'b00, 0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 3, 0, 1, 32'h4C);
    tbl[8]  = mk(32'h40, 6'h30, 2'b00, 7, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10, 0, 1, 32'h4C);
    tbl[9]  = mk(0, 6'h0A, 2'b00, 32'h80000000, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hF8000000, 0, 0, 16);
    tbl[10] = mk(0, 6'h0B, 2'b00, 32'h80000000, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h08000000, 0, 0, 16);
    tbl[11] = mk(0, 6'h09, 2'b00, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0, 16);
    tbl[12] = mk(0, 6'h0F, 2'b00, 32'h80000000, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16);
    tbl[13] = mk(32'h80, 6'h20, 2'b00, 9, 0, 0, 5, 6, 5, 1, 2, 6, 1, 2, 2, 2, 0, 32'h80);
    tbl[14] = mk(4, 6'h00, 2'b00, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(rv, "reset");
    repeat (2) @(posedge clk);
    #1;
    chk("reset alu_after_edge", bus.ALU_res_out_EXE, 0);
    rst = 0;
    foreach (tbl[i]) begin
      tbl[i].wb = 1'(i);
      tbl[i].dst = 5'(i * 3);
      apply(tbl[i], $sformatf("vec%0d", i));
    end
    for (int n = 0; n < 400; n++) begin
      rv.pc = $urandom; rv.v1 = $urandom; rv.v2 = $urandom; rv.r2 = $urandom;
      rv.rm = $urandom; rv.rw = $urandom;
      rv.cmd = 6'($urandom); rv.mem = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      rv.s1 = 5'($urandom_range(0, 3)); rv.s2 = 5'($urandom_range(0, 3));
      rv.dm = 5'($urandom_range(0, 3)); rv.dw = 5'($urandom_range(0, 3));
      rv.em = 1'($urandom); rv.ew = 1'($urandom); rv.wb = 1'($urandom); rv.dst = 5'($urandom);
      if (n % 4 == 0) rv.v1 = rv.r2;
      if (n % 8 == 1) rv.v1 = 0;
      apply(ref_model(rv), $sformatf("rand%0d", n));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
